// File: rtl/stream_pkg.sv
// Shared constants for the reader-to-writer elastic buffer.
// State encoding is kept as plain 2-bit constants for compatibility with older consumers.
package stream_pkg;

    localparam int DATA_WIDTH_DEF = 7;
    localparam int ADDR_WIDTH_DEF = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/stream_fifo_if.sv
// Handshake bundle between the file reader (upstream) and the file writer (downstream).
// master = environment side, slave = the buffer.
interface stream_fifo_if #(
    parameter int DATA_WIDTH = stream_pkg::DATA_WIDTH_DEF
);
    logic                  in_valid;
    logic [DATA_WIDTH:0]   in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  out_ready;
    logic                  out_enable;
    logic [DATA_WIDTH:0]   out_data;
    logic                  out_done;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_enable, out_data, out_done
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_enable, out_data, out_done
    );
endinterface

// File: rtl/stream_fifo_mem.sv
// Register-array storage: synchronous write, combinational read.
// The array is deliberately unreset; pointers alone define which entries are live.
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH:0]   wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH:0]   rdata
);

    logic [DATA_WIDTH:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Elastic buffer from file reader to file writer: buffers bytes, replays them as enable
// pulses, and raises done only once the final byte has actually been emitted.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_fifo_if.slave      s,
    output logic [ADDR_WIDTH:0] count,
    output logic              overflow
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic [1:0]          state, state_nxt;
    logic                empty, full, accepting, push, pop;
    logic [DATA_WIDTH:0] head;
    logic                out_en_q;
    logic [DATA_WIDTH:0] out_data_q;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                       (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign accepting = (state == IDLE) || (state == STREAM);
    assign count     = wr_ptr - rd_ptr;

    // Gated by rst_n so the reader sees no ready while the block is held in reset.
    assign s.in_ready = rst_n && accepting && !full;
    assign push       = s.in_valid && s.in_ready;
    assign pop        = s.out_ready && !empty && (state != DONE);

    assign s.out_enable = out_en_q;
    assign s.out_data   = out_data_q;
    assign s.out_done   = (state == DONE);

    stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (s.in_data),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (head)
    );

    // In DRAIN no pushes occur, so popping the sole remaining word is the final pop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push) state_nxt = s.in_last ? DRAIN : STREAM;
            STREAM:  if (push && s.in_last) state_nxt = DRAIN;
            DRAIN:   if (pop && (count == PTR_ONE)) state_nxt = DONE;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_en_q   <= 1'b0;
            out_data_q <= '0;
            overflow   <= 1'b0;
        end else begin
            state    <= state_nxt;
            out_en_q <= pop;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                out_data_q <= head;
            end
            if (s.in_valid && !accepting) overflow <= 1'b1;
        end
    end

endmodule
